// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-stage types used by the fetch block and the decoder.
package isa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam int DEF_PC_W   = 10;
   localparam int DEF_LUT_AW = 6;
   localparam int DEF_CNT_W  = 16;

   // Opcode field values and the halt encoding, kept here so the decoder sees the same map.
   localparam logic [2:0] OP_BRANCH = 3'b100;
   localparam logic [2:0] OP_STORE  = 3'b101;
   localparam logic [2:0] OP_LOAD   = 3'b110;
   localparam logic [2:0] OP_MOVE   = 3'b111;
   localparam logic [8:0] HALT_WORD = 9'b011111111;

endpackage

// File: rtl/jump_lut.sv
// Branch-target table: one synchronous write port, one combinational read port.
module jump_lut #(
   parameter int AW = 6,
   parameter int DW = 10
) (
   input  logic          Clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];

   // NOTE: the table has no reset; targets are loaded by software and must survive a core reset.
   always_ff @(posedge Clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_counter_fetch.sv
// Fetch stage: owns the PC, sequences it through increment / LUT branch / halt,
// and runs the start/halt handshake with the top level.
module prog_counter_fetch
   import isa_pkg::*;
#(
   parameter int PC_W   = DEF_PC_W,
   parameter int LUT_AW = DEF_LUT_AW,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [PC_W-1:0]   StartAddr,
   input  logic              Jen,
   input  logic [7:0]        Jptr,
   input  logic              BranchCond,
   input  logic              Done,
   input  logic              LutWe,
   input  logic [LUT_AW-1:0] LutWaddr,
   input  logic [PC_W-1:0]   LutWdata,
   output logic [PC_W-1:0]   Prog_ctr,
   output logic              Running,
   output logic              Halted,
   output logic [CNT_W-1:0]  CycleCnt
);

   fetch_state_t     r_state;
   fetch_state_t     w_next_state;
   logic [PC_W-1:0]  r_pc;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [PC_W-1:0]  w_lut_target;
   logic             w_stopped;
   logic             w_launch;
   logic             w_lut_we;
   logic             w_taken;
   logic             w_unused_jptr;

   assign w_stopped     = (r_state == IDLE) || (r_state == HALT);
   assign w_launch      = w_stopped && Start;
   assign w_lut_we      = w_stopped && LutWe && !Reset;
   assign w_taken       = Jen && BranchCond;
   assign w_unused_jptr = ^Jptr[7:LUT_AW];

   jump_lut #(
      .AW (LUT_AW),
      .DW (PC_W)
   ) u_jump_lut (
      .Clk     (Clk),
      .i_we    (w_lut_we),
      .i_waddr (LutWaddr),
      .i_wdata (LutWdata),
      .i_raddr (Jptr[LUT_AW-1:0]),
      .o_rdata (w_lut_target)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: the default assignment up front keeps this block free of inferred latches.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, HALT: if (Start) w_next_state = RUN;
         RUN:        if (Done)  w_next_state = HALT;
         default:    w_next_state = IDLE;
      endcase
   end

   always_comb begin
      Running = (r_state == RUN);
      Halted  = (r_state == HALT);
   end

   // Done freezes the PC on the halt word, but the cycle counter still counts that edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pc        <= '0;
         r_cycle_cnt <= '0;
      end else if (w_launch) begin
         r_pc        <= StartAddr;
         r_cycle_cnt <= '0;
      end else if (r_state == RUN) begin
         if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
         if (!Done) begin
            if (w_taken) r_pc <= w_lut_target;
            else         r_pc <= r_pc + 1'b1;
         end
      end
   end

   assign Prog_ctr = r_pc;
   assign CycleCnt = r_cycle_cnt;

endmodule

// File: tb/tb_prog_counter_fetch.sv
// Directed scoreboard bench for prog_counter_fetch: stimulus queues expectations, a monitor checks them.
module tb_prog_counter_fetch;

   typedef struct {
      string       name;
      logic [9:0]  pc;
      logic        run;
      logic        halt;
      logic [15:0] cnt;
   } exp_t;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [9:0]  StartAddr;
   logic        Jen;
   logic [7:0]  Jptr;
   logic        BranchCond;
   logic        Done;
   logic        LutWe;
   logic [5:0]  LutWaddr;
   logic [9:0]  LutWdata;
   logic [9:0]  Prog_ctr;
   logic        Running;
   logic        Halted;
   logic [15:0] CycleCnt;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   prog_counter_fetch dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .StartAddr  (StartAddr),
      .Jen        (Jen),
      .Jptr       (Jptr),
      .BranchCond (BranchCond),
      .Done       (Done),
      .LutWe      (LutWe),
      .LutWaddr   (LutWaddr),
      .LutWdata   (LutWdata),
      .Prog_ctr   (Prog_ctr),
      .Running    (Running),
      .Halted     (Halted),
      .CycleCnt   (CycleCnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input exp_t e);
      checks++;
      if (Prog_ctr !== e.pc || Running !== e.run || Halted !== e.halt || CycleCnt !== e.cnt) begin
         errors++;
         $display("FAIL %s: got pc=%h run=%b halt=%b cnt=%h, expected pc=%h run=%b halt=%b cnt=%h",
                  e.name, Prog_ctr, Running, Halted, CycleCnt, e.pc, e.run, e.halt, e.cnt);
      end
   endtask

   // Monitor: outputs are stable away from the rising edge, so compare on the falling edge.
   initial begin
      forever begin
         @(negedge Clk);
         while (exp_q.size() > 0) check(exp_q.pop_front());
      end
   end

   task automatic tick(input string nm, input logic [9:0] pc, input logic run,
                       input logic halt, input logic [15:0] cnt);
      exp_t e;
      @(posedge Clk);
      #1;
      e.name = nm;
      e.pc   = pc;
      e.run  = run;
      e.halt = halt;
      e.cnt  = cnt;
      exp_q.push_back(e);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; StartAddr = '0; Jen = 1'b0; Jptr = '0;
      BranchCond = 1'b0; Done = 1'b0; LutWe = 1'b0; LutWaddr = '0; LutWdata = '0;

      tick("reset_state", 10'h000, 1'b0, 1'b0, 16'h0000);
      Reset = 1'b0;

      // Preload the jump table while idle.
      LutWe = 1'b1; LutWaddr = 6'd3; LutWdata = 10'h040;
      tick("lut_load3", 10'h000, 1'b0, 1'b0, 16'h0000);
      LutWaddr = 6'd5; LutWdata = 10'h123;
      tick("lut_load5", 10'h000, 1'b0, 1'b0, 16'h0000);
      LutWaddr = 6'd2; LutWdata = 10'h0AB;
      tick("lut_load2", 10'h000, 1'b0, 1'b0, 16'h0000);
      LutWe = 1'b0;

      // Launch and sequential increment.
      Start = 1'b1; StartAddr = 10'h010;
      tick("launch_010", 10'h010, 1'b1, 1'b0, 16'h0000);
      Start = 1'b0;
      tick("inc_011", 10'h011, 1'b1, 1'b0, 16'h0001);
      tick("inc_012", 10'h012, 1'b1, 1'b0, 16'h0002);

      // Taken branch ignores Jptr[7:6]; untaken branch increments.
      Jen = 1'b1; Jptr = 8'hC5; BranchCond = 1'b1;
      tick("branch_taken", 10'h123, 1'b1, 1'b0, 16'h0003);
      BranchCond = 1'b0;
      tick("branch_not_taken", 10'h124, 1'b1, 1'b0, 16'h0004);

      // Done beats a simultaneous taken branch.
      Done = 1'b1; Jptr = 8'h03; BranchCond = 1'b1;
      tick("done_wins", 10'h124, 1'b0, 1'b1, 16'h0005);
      Jen = 1'b0; BranchCond = 1'b0;
      tick("halt_hold", 10'h124, 1'b0, 1'b1, 16'h0005);
      Start = 1'b1; StartAddr = 10'h020;
      tick("relaunch_020", 10'h020, 1'b1, 1'b0, 16'h0000);
      Start = 1'b0; Done = 1'b0;
      tick("inc_021", 10'h021, 1'b1, 1'b0, 16'h0001);

      // Table writes and Start are ignored while running.
      LutWe = 1'b1; LutWaddr = 6'd2; LutWdata = 10'h3AA; Start = 1'b1; StartAddr = 10'h200;
      tick("run_ignores_we", 10'h022, 1'b1, 1'b0, 16'h0002);
      LutWe = 1'b0; Start = 1'b0;
      Jen = 1'b1; BranchCond = 1'b1; Jptr = 8'h02;
      tick("lut2_unchanged", 10'h0AB, 1'b1, 1'b0, 16'h0003);
      Jen = 1'b0; BranchCond = 1'b0;
      Done = 1'b1;
      tick("halt_at_0ab", 10'h0AB, 1'b0, 1'b1, 16'h0004);
      Done = 1'b0;

      // PC wraps at the top of the address space.
      Start = 1'b1; StartAddr = 10'h3FE;
      tick("launch_3fe", 10'h3FE, 1'b1, 1'b0, 16'h0000);
      Start = 1'b0;
      tick("inc_3ff", 10'h3FF, 1'b1, 1'b0, 16'h0001);
      tick("wrap_000", 10'h000, 1'b1, 1'b0, 16'h0002);
      for (int i = 1; i <= 5; i++)
         tick("run_to_005", 10'(i), 1'b1, 1'b0, 16'(i + 2));

      // Reset mid-run dominates Start and LutWe; the table survives it.
      Reset = 1'b1; Start = 1'b1; StartAddr = 10'h155; LutWe = 1'b1; LutWaddr = 6'd3; LutWdata = 10'h111;
      tick("reset_mid_run", 10'h000, 1'b0, 1'b0, 16'h0000);
      tick("reset_held", 10'h000, 1'b0, 1'b0, 16'h0000);
      Reset = 1'b0; Start = 1'b0; LutWe = 1'b0;
      tick("idle_after_reset", 10'h000, 1'b0, 1'b0, 16'h0000);
      Start = 1'b1; StartAddr = 10'h050;
      tick("launch_050", 10'h050, 1'b1, 1'b0, 16'h0000);
      Start = 1'b0; Jen = 1'b1; BranchCond = 1'b1; Jptr = 8'h43;
      tick("lut3_kept", 10'h040, 1'b1, 1'b0, 16'h0001);
      Jen = 1'b0; BranchCond = 1'b0;

      // Preset the counter near its ceiling, after the monitor has sampled this cycle.
      @(negedge Clk);
      #1 force dut.r_cycle_cnt = 16'hFFFD;
      #1 release dut.r_cycle_cnt;
      tick("cnt_fffe", 10'h041, 1'b1, 1'b0, 16'hFFFE);
      tick("cnt_ffff", 10'h042, 1'b1, 1'b0, 16'hFFFF);
      tick("cnt_saturated", 10'h043, 1'b1, 1'b0, 16'hFFFF);
      Done = 1'b1;
      tick("halt_saturated", 10'h043, 1'b0, 1'b1, 16'hFFFF);

      // A table write in HALT is visible to the first branch after relaunch.
      LutWe = 1'b1; LutWaddr = 6'd7; LutWdata = 10'h155;
      tick("halt_lut_write", 10'h043, 1'b0, 1'b1, 16'hFFFF);
      LutWe = 1'b0; Done = 1'b0; Start = 1'b1; StartAddr = 10'h100;
      tick("launch_100", 10'h100, 1'b1, 1'b0, 16'h0000);
      Start = 1'b0; Jen = 1'b1; BranchCond = 1'b1; Jptr = 8'h07;
      tick("branch_new_entry", 10'h155, 1'b1, 1'b0, 16'h0001);
      Jen = 1'b0; BranchCond = 1'b0;

      repeat (3) @(negedge Clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
